corner_cursor_ctrl: RTL
=======================

// Module: corner_cursor_ctrl
// PURPOSE
//  Upstream of the corner crosshair sprites. Holds the four user-placed quad corners (TL,TR,BR,BL) and moves
//  the selected one with debounced buttons, once per video frame. Feeds sel_x/sel_y to the highlighted sprite,
//  the packed corner bus to the other sprites, and locked/lock_pulse to the rectilinearizer core.
// PARAMETERS
//  H_ACTIVE  1024  visible pixels per line; x range 0..H_ACTIVE-1
//  V_ACTIVE  768   visible lines; y range 0..V_ACTIVE-1
//  MARGIN    100   reset inset of corners from screen edge
//  STEP      2     pixels moved per frame tick while a direction is held
//  HOLD_FR   30    frames held before acceleration (CORNER_ACCEL_EN only)
// PORTS
//  clock       in   1   pixel clock; all state on rising edge
//  reset       in   1   synchronous, active-high
//  vsync       in   1   active-low vsync from the xvga timing generator
//  btn_up/btn_down/btn_left/btn_right  in  1 each  debounced, level, active-high
//  btn_next    in   1   debounced level; rising edge cycles the selection
//  btn_enter   in   1   debounced level; rising edge toggles ADJUST/LOCKED
//  corners_x   out  44  {c3,c2,c1,c0} x, 11 bits each
//  corners_y   out  40  {c3,c2,c1,c0} y, 10 bits each
//  sel         out  2   selected corner index 0..3
//  sel_x       out  11  x of selected corner;  sel_y  out  10  y of selected corner
//  locked      out  1   1 in LOCKED state;  lock_pulse  out  1  one-cycle pulse on ADJUST->LOCKED
// BEHAVIOUR
//  - Reset: state=ADJUST, sel=0, locked=0, lock_pulse=0; c0=(MARGIN,MARGIN), c1=(H_ACTIVE-1-MARGIN,MARGIN),
//    c2=(H_ACTIVE-1-MARGIN,V_ACTIVE-1-MARGIN), c3=(MARGIN,V_ACTIVE-1-MARGIN); defaults: (100,100),(923,100),(923,667),(100,667).
//  - Edge detect: vsync, btn_next and btn_enter each registered once; frame_tick = vsync 1->0;
//    next_rise / enter_rise = 0->1. First event is usable one cycle after reset deasserts (history regs reset to
//    the idle level: vsync=1, buttons=0).
//  - FSM: ADJUST --enter_rise--> LOCKED (lock_pulse=1 that cycle, locked=1 next cycle).
//    LOCKED --enter_rise--> ADJUST. No other transitions. Corners and sel frozen in LOCKED.
//  - ADJUST, next_rise: sel <= sel+1, wrapping 3->0.
//  - ADJUST, frame_tick: dx = (right&~left)?+d : (left&~right)?-d : 0; dy similarly with down(+)/up(-);
//    d=STEP. Both opposing buttons held -> no motion on that axis.
//  - Arithmetic in 13-bit signed; result clamped to [0,H_ACTIVE-1] / [0,V_ACTIVE-1]; never wraps.
//  - Simultaneous events in one cycle: enter_rise beats everything (no move, no sel change that cycle);
//    next_rise + frame_tick: move applies to the old sel, new sel takes effect next cycle.
//  - sel_x/sel_y combinational mux of registered corners by registered sel (zero extra latency).
//  - Corner outputs change only on the cycle after frame_tick, i.e. during vertical blanking; no mid-frame tear.
//  - Reset mid-operation: all state returns to reset values on the next edge regardless of state or buttons.
// CONFIGURATION
//  CORNER_ACCEL_EN defined: per-axis hold counter counts frame ticks a direction stays held (saturates at HOLD_FR);
//    once it reaches HOLD_FR, d=4*STEP; counter clears when that axis is released or sel changes.
//  CORNER_ACCEL_EN undefined: d=STEP always; no hold counters synthesised.
// TESTING
//  1 reset, idle 3 frames -> corners_x={11'd100,11'd923,11'd923,11'd100}, sel=0, locked=0, sel_x=100,sel_y=100.
//  2 hold btn_right 10 frames, sel=0 -> c0.x=120 after 10th tick; c0.y and c1..c3 unchanged.
//  3 sel=1, hold btn_right 100 frames -> c1.x saturates at 1023, never wraps to small value.
//  4 pulse btn_next 5 times -> sel=1,2,3,0,1; sel_x/sel_y track the selected corner each cycle.
//  5 btn_enter rise -> lock_pulse one cycle, locked=1; held directions for 5 frames -> no corner change; enter again -> ADJUST.
//  6 next_rise coincident with frame_tick, right held -> old corner moves +2, sel increments; enter+tick same cycle -> no move.
//    With CORNER_ACCEL_EN: hold left from (100,100) 40 frames -> x=100-29*2-11*8=... clamps at 0.

Source files
------------

// File: rtl/corner_cursor_ctrl.sv
// Quad-corner cursor controller: four user-placed corners, frame-rate nudging of the selected one, lock toggle.
// Optional build macro CORNER_ACCEL_EN enables per-axis hold acceleration after HOLD_FR held frames.
module corner_cursor_ctrl #(
  parameter int H_ACTIVE = 1024,
  parameter int V_ACTIVE = 768,
  parameter int MARGIN   = 100,
  parameter int STEP     = 2
`ifdef CORNER_ACCEL_EN
  , parameter int HOLD_FR = 30
`endif
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        vsync,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_next,
  input  logic        btn_enter,
  output logic [43:0] corners_x,
  output logic [39:0] corners_y,
  output logic [1:0]  sel,
  output logic [10:0] sel_x,
  output logic [9:0]  sel_y,
  output logic        locked,
  output logic        lock_pulse
);

  typedef enum logic {ADJUST = 1'b0, LOCKED = 1'b1} state_t;

  localparam logic [10:0]        X_LO  = 11'(MARGIN);
  localparam logic [10:0]        X_HI  = 11'(H_ACTIVE - 1 - MARGIN);
  localparam logic [9:0]         Y_LO  = 10'(MARGIN);
  localparam logic [9:0]         Y_HI  = 10'(V_ACTIVE - 1 - MARGIN);
  localparam logic signed [12:0] X_MAX = 13'(H_ACTIVE - 1);
  localparam logic signed [12:0] Y_MAX = 13'(V_ACTIVE - 1);

  state_t      state_q, state_d;
  logic        vsync_q, next_q, enter_q;
  logic [1:0]  sel_q, sel_d;
  logic [10:0] cx_q [4];
  logic [10:0] cx_d [4];
  logic [9:0]  cy_q [4];
  logic [9:0]  cy_d [4];

  logic frame_tick, next_rise, enter_rise;
  logic x_move, y_move;
  logic signed [12:0] step_x, step_y, dx, dy, nx, ny;

  assign frame_tick = vsync_q & ~vsync;
  assign next_rise  = ~next_q & btn_next;
  assign enter_rise = ~enter_q & btn_enter;

  // Opposing buttons on one axis cancel each other.
  assign x_move = btn_right ^ btn_left;
  assign y_move = btn_down ^ btn_up;

`ifdef CORNER_ACCEL_EN
  localparam int CW = $clog2(HOLD_FR + 1);
  logic [CW-1:0] hx_q, hx_d, hy_q, hy_d;

  // Fast step starts on the tick where the held count reaches HOLD_FR.
  assign step_x = (hx_q >= CW'(HOLD_FR - 1)) ? 13'(4 * STEP) : 13'(STEP);
  assign step_y = (hy_q >= CW'(HOLD_FR - 1)) ? 13'(4 * STEP) : 13'(STEP);
`else
  assign step_x = 13'(STEP);
  assign step_y = 13'(STEP);
`endif

  assign dx = !x_move ? 13'sd0 : (btn_right ? step_x : -step_x);
  assign dy = !y_move ? 13'sd0 : (btn_down  ? step_y : -step_y);
  assign nx = $signed({2'b00, cx_q[sel_q]}) + dx;
  assign ny = $signed({3'b000, cy_q[sel_q]}) + dy;

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    cx_d       = cx_q;
    cy_d       = cy_q;
    lock_pulse = 1'b0;
`ifdef CORNER_ACCEL_EN
    hx_d = hx_q;
    hy_d = hy_q;
`endif
    if (enter_rise) begin
      state_d    = (state_q == ADJUST) ? LOCKED : ADJUST;
      lock_pulse = (state_q == ADJUST) & ~reset;
    end else if (state_q == ADJUST) begin
      if (frame_tick) begin
        if (nx < 13'sd0)       cx_d[sel_q] = 11'd0;
        else if (nx > X_MAX)   cx_d[sel_q] = 11'(H_ACTIVE - 1);
        else                   cx_d[sel_q] = nx[10:0];
        if (ny < 13'sd0)       cy_d[sel_q] = 10'd0;
        else if (ny > Y_MAX)   cy_d[sel_q] = 10'(V_ACTIVE - 1);
        else                   cy_d[sel_q] = ny[9:0];
`ifdef CORNER_ACCEL_EN
        hx_d = !x_move ? '0 : (hx_q >= CW'(HOLD_FR) ? hx_q : hx_q + 1'b1);
        hy_d = !y_move ? '0 : (hy_q >= CW'(HOLD_FR) ? hy_q : hy_q + 1'b1);
`endif
      end
      if (next_rise) begin
        sel_d = sel_q + 2'd1;
`ifdef CORNER_ACCEL_EN
        hx_d = '0;
        hy_d = '0;
`endif
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ADJUST;
      sel_q   <= 2'd0;
      vsync_q <= 1'b1;
      next_q  <= 1'b0;
      enter_q <= 1'b0;
      cx_q[0] <= X_LO;  cy_q[0] <= Y_LO;
      cx_q[1] <= X_HI;  cy_q[1] <= Y_LO;
      cx_q[2] <= X_HI;  cy_q[2] <= Y_HI;
      cx_q[3] <= X_LO;  cy_q[3] <= Y_HI;
`ifdef CORNER_ACCEL_EN
      hx_q <= '0;
      hy_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      vsync_q <= vsync;
      next_q  <= btn_next;
      enter_q <= btn_enter;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
`ifdef CORNER_ACCEL_EN
      hx_q <= hx_d;
      hy_q <= hy_d;
`endif
    end
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_pack
    assign corners_x[gi*11 +: 11] = cx_q[gi];
    assign corners_y[gi*10 +: 10] = cy_q[gi];
  end

  assign sel    = sel_q;
  assign sel_x  = cx_q[sel_q];
  assign sel_y  = cy_q[sel_q];
  assign locked = (state_q == LOCKED);

endmodule
